dram_access_sched: RTL and testbench
====================================

Name: dram_access_sched

Overview:
- Scheduler in front of the 16-bit DRAM write/read sequencer (the IO_EN / IO_MODEL / DRAM16_data command port, completing on WT_DONE / RD_DONE).
- Shares that single command port between two requesters (req0 = host IO, req1 = LIM/compute engine) and an internal periodic row-refresh generator.
- Issues one command at a time, waits for completion, returns read data and a done pulse to the owner.

Parameters:
- ROW_W, 4, row address width; refresh walks 0..2^ROW_W-1.
- REF_PERIOD, 1024, cycles between refresh requests (must be >= 2).
- TIMEOUT, 255, max WAIT cycles before abort (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- reqN_valid  in  1  request pending, N = 0,1 (held until reqN_grant).
- reqN_model  in  2  01 = write, 10 = read; 00/11 illegal.
- reqN_row  in  ROW_W  target row.
- reqN_data  in  [16:1]  write data.
- reqN_grant  out  1  one-cycle pulse: request accepted.
- reqN_done  out  1  one-cycle pulse: request finished.
- reqN_err  out  1  qualifies reqN_done: illegal model or timeout.
- rd_data  out  [16:1]  read result; valid with reqN_done for reads; held until the next read completes.
- IO_EN  out  1  one-cycle command strobe to the sequencer.
- IO_MODEL  out  2  01 write, 10 read, 11 refresh.
- DRAM16_data  out  [16:1]  write data to the sequencer.
- ROW_AD  out  ROW_W  row address to the sequencer.
- WT_DONE  in  1  write complete.
- RD_DONE  in  1  read/refresh complete.
- RD_DATA  in  [16:1]  sequencer read data, valid with RD_DONE.
- busy  out  1  FSM not IDLE.
- ref_miss  out  1  sticky: a refresh period expired while a refresh was still pending.
- timeout_err  out  1  sticky: any WAIT timeout.

Behaviour:
- Reset: every output is 0, including the sticky flags and rd_data. FSM = IDLE, ref timer = 0, ref_row = 0, ref_pending = 0, rr_ptr = 0 (req0 favoured).

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, priority order:
  - ref_pending → owner = REF, go to ISSUE.
  - Else one valid requester → grant it.
  - Else both valid → grant rr_ptr's requester.
  - Granting: reqN_grant pulses this cycle, inputs are latched, go to ISSUE.
  - Illegal model: grant, then go directly to DONE with err = 1; no IO_EN.
- ISSUE (1 cycle): IO_EN = 1; IO_MODEL / ROW_AD / DRAM16_data driven from the latched values.
  - REF: IO_MODEL = 11, ROW_AD = ref_row, data = 0.
  - Go to WAIT.
- WAIT:
  - Completion is WT_DONE for model 01, RD_DONE for 10/11. The non-matching done is ignored.
  - On completion: capture RD_DATA for reads, go to DONE.
  - Wait counter reaches TIMEOUT: set timeout_err, err = 1, go to DONE.
- DONE (1 cycle):
  - Owner N: reqN_done = 1 and reqN_err = err; rd_data updated on a successful read.
  - After a requester completes, rr_ptr = other requester.
  - REF: no requester pulse; clear ref_pending; ref_row += 1, wrapping 2^ROW_W-1 → 0. A refresh timeout does not advance ref_row.
  - Go to IDLE.
- Latency: grant at cycle T, IO_EN at T+1, done detected at M, reqN_done at M+1. Minimum grant-to-done is 3 cycles.
- IO_MODEL / ROW_AD / DRAM16_data hold their values from ISSUE through DONE, then return to 0 in IDLE.

Refresh timer:
- Free-running; at REF_PERIOD-1 it wraps to 0 and sets ref_pending.
- If ref_pending is already 1 at the wrap, set ref_miss.
- The timer runs in all states; refresh never preempts a command in flight.

Simultaneous events:
- ref_pending set in the same cycle as a grant: the grant wins; the refresh goes next.
- A requester dropping valid before grant is legal: no grant is issued.
- reqN_valid is ignored while busy.

Reset mid-operation: everything returns to reset values next cycle, with no done pulse. IO_EN low from the cycle after rst.

Optional Feature:
- DRAM_REFRESH_EN defined: refresh timer, REF arbitration, ref_row and ref_miss as above.
- Undefined:
  - No timer logic; ref_pending constant 0; ref_miss tied 0.
  - IO_MODEL never 11; arbitration is pure round-robin between req0/req1.

Test Plan:
- Reset: hold rst 3 cycles mid-WAIT → all outputs 0, no reqN_done; next req0 write is granted normally.
- req0 write row 3 data 16'hA5A5 → grant T, IO_EN=1 / IO_MODEL=01 / ROW_AD=3 / DRAM16_data=A5A5 at T+1; WT_DONE at T+5 → req0_done at T+6, req0_err=0.
- req0 and req1 both reading in the same cycle, repeated 4 times → grant order 0,1,0,1; RD_DATA 16'h1234 returned on rd_data with the correct reqN_done.
- DRAM_REFRESH_EN, REF_PERIOD=16, ROW_W=2, RD_DONE 2 cycles after each IO_EN → IO_MODEL=11 with ROW_AD 0,1,2,3,0; refresh wins over a simultaneous req1; ref_miss stays 0.
- REF_PERIOD=16 with a write stalled 40 cycles → ref_miss=1.
- TIMEOUT=8, no done returned → req1_done with req1_err=1 on the 9th WAIT cycle; timeout_err sticky; next request still served.
- req0_model=00 → grant then req0_done + req0_err, IO_EN never asserted.

Source files
------------

// File: rtl/dram_access_sched.sv
// Arbitrates the single DRAM sequencer command port between two requesters and a refresh generator.
// Optional periodic row refresh is compiled in when DRAM_REFRESH_EN is defined.
module dram_access_sched #(
    parameter int unsigned ROW_W      = 4,
    parameter int unsigned REF_PERIOD = 1024,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_model,
    input  logic [ROW_W-1:0] req0_row,
    input  logic [16:1]      req0_data,
    output logic             req0_grant,
    output logic             req0_done,
    output logic             req0_err,
    input  logic             req1_valid,
    input  logic [1:0]       req1_model,
    input  logic [ROW_W-1:0] req1_row,
    input  logic [16:1]      req1_data,
    output logic             req1_grant,
    output logic             req1_done,
    output logic             req1_err,
    output logic [16:1]      rd_data,
    output logic             IO_EN,
    output logic [1:0]       IO_MODEL,
    output logic [16:1]      DRAM16_data,
    output logic [ROW_W-1:0] ROW_AD,
    input  logic             WT_DONE,
    input  logic             RD_DONE,
    input  logic [16:1]      RD_DATA,
    output logic             busy,
    output logic             ref_miss,
    output logic             timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_REQ0, OWN_REQ1, OWN_REF} owner_t;

    localparam logic [1:0] MODEL_WR  = 2'b01;
    localparam logic [1:0] MODEL_RD  = 2'b10;
    localparam logic [1:0] MODEL_REF = 2'b11;

    localparam int unsigned   CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    if (REF_PERIOD < 2 || TIMEOUT < 1) begin : g_param_check
        $error("dram_access_sched: REF_PERIOD must be >= 2 and TIMEOUT >= 1");
    end

    state_t           state, state_nxt;
    owner_t           owner;
    logic [1:0]       lat_model;
    logic [ROW_W-1:0] lat_row;
    logic [16:1]      lat_data;
    logic             err;
    logic             rr_ptr;
    logic [CW-1:0]    wait_cnt;

    logic             ref_pending;
    logic [ROW_W-1:0] ref_row;

    logic             pick1, take_ref, take0, take1;
    logic [1:0]       sel_model;
    logic [ROW_W-1:0] sel_row;
    logic [16:1]      sel_data;
    logic             sel_legal;
    logic             complete, timeout_hit;

    // Round-robin only breaks ties; a lone requester is always served.
    assign pick1     = req1_valid && (!req0_valid || rr_ptr);
    assign take_ref  = !rst && (state == IDLE) && ref_pending;
    assign take0     = !rst && (state == IDLE) && !ref_pending && req0_valid && !pick1;
    assign take1     = !rst && (state == IDLE) && !ref_pending && pick1;
    assign sel_model = take1 ? req1_model : req0_model;
    assign sel_row   = take1 ? req1_row   : req0_row;
    assign sel_data  = take1 ? req1_data  : req0_data;
    assign sel_legal = (sel_model == MODEL_WR) || (sel_model == MODEL_RD);

    always_comb begin
        state_nxt   = state;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (take_ref || ((take0 || take1) && sel_legal))
                    state_nxt = ISSUE;
                else if (take0 || take1)
                    state_nxt = DONE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                complete    = (lat_model == MODEL_WR) ? WT_DONE : RD_DONE;
                timeout_hit = !complete && (wait_cnt == WAIT_LAST);
                if (complete || timeout_hit)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_REQ0;
            lat_model   <= '0;
            lat_row     <= '0;
            lat_data    <= '0;
            err         <= 1'b0;
            rr_ptr      <= 1'b0;
            wait_cnt    <= '0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (take_ref) begin
                        owner     <= OWN_REF;
                        lat_model <= MODEL_REF;
                        lat_row   <= ref_row;
                        lat_data  <= '0;
                        err       <= 1'b0;
                    end else if (take0 || take1) begin
                        // Illegal commands keep the port fields at zero so nothing leaks out.
                        owner     <= take1 ? OWN_REQ1 : OWN_REQ0;
                        lat_model <= sel_legal ? sel_model : '0;
                        lat_row   <= sel_legal ? sel_row : '0;
                        lat_data  <= sel_legal ? sel_data : '0;
                        err       <= !sel_legal;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (complete && (lat_model == MODEL_RD))
                        rd_data <= RD_DATA;
                    if (timeout_hit) begin
                        err         <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                DONE: begin
                    if (owner == OWN_REQ0)
                        rr_ptr <= 1'b1;
                    else if (owner == OWN_REQ1)
                        rr_ptr <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DRAM_REFRESH_EN
    localparam int unsigned   TW       = $clog2(REF_PERIOD);
    localparam logic [TW-1:0] TMR_LAST = TW'(REF_PERIOD - 1);

    logic [TW-1:0] ref_tmr;
    logic          ref_wrap, ref_clr;

    assign ref_wrap = (ref_tmr == TMR_LAST);
    assign ref_clr  = (state == DONE) && (owner == OWN_REF);

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_tmr     <= '0;
            ref_pending <= 1'b0;
            ref_row     <= '0;
            ref_miss    <= 1'b0;
        end else begin
            ref_tmr <= ref_wrap ? '0 : ref_tmr + 1'b1;
            // A new period beats the clear of the refresh finishing in the same cycle.
            if (ref_wrap) begin
                ref_pending <= 1'b1;
                if (ref_pending)
                    ref_miss <= 1'b1;
            end else if (ref_clr) begin
                ref_pending <= 1'b0;
            end
            if (ref_clr && !err)
                ref_row <= ref_row + 1'b1;
        end
    end
`else
    assign ref_pending = 1'b0;
    assign ref_row     = '0;
    assign ref_miss    = 1'b0;
`endif

    assign req0_grant  = take0;
    assign req1_grant  = take1;
    assign req0_done   = !rst && (state == DONE) && (owner == OWN_REQ0);
    assign req1_done   = !rst && (state == DONE) && (owner == OWN_REQ1);
    assign req0_err    = req0_done && err;
    assign req1_err    = req1_done && err;
    assign IO_EN       = !rst && (state == ISSUE);
    assign IO_MODEL    = (state == IDLE) ? '0 : lat_model;
    assign ROW_AD      = (state == IDLE) ? '0 : lat_row;
    assign DRAM16_data = (state == IDLE) ? '0 : lat_data;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dram_access_sched.sv
// Directed bench for dram_access_sched; refresh scenarios use a second instance when DRAM_REFRESH_EN is defined.
module tb_dram_access_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_model, req1_model;
    logic [3:0]  req0_row, req1_row;
    logic [16:1] req0_data, req1_data;
    logic        req0_grant, req0_done, req0_err;
    logic        req1_grant, req1_done, req1_err;
    logic [16:1] rd_data;
    logic        IO_EN;
    logic [1:0]  IO_MODEL;
    logic [16:1] DRAM16_data;
    logic [3:0]  ROW_AD;
    logic        WT_DONE, RD_DONE;
    logic [16:1] RD_DATA;
    logic        busy, ref_miss, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dram_access_sched #(.ROW_W(4), .REF_PERIOD(1024), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_model(req0_model), .req0_row(req0_row), .req0_data(req0_data),
        .req0_grant(req0_grant), .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_model(req1_model), .req1_row(req1_row), .req1_data(req1_data),
        .req1_grant(req1_grant), .req1_done(req1_done), .req1_err(req1_err),
        .rd_data(rd_data), .IO_EN(IO_EN), .IO_MODEL(IO_MODEL), .DRAM16_data(DRAM16_data),
        .ROW_AD(ROW_AD), .WT_DONE(WT_DONE), .RD_DONE(RD_DONE), .RD_DATA(RD_DATA),
        .busy(busy), .ref_miss(ref_miss), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err, busy, IO_EN,
                    IO_MODEL, ROW_AD, DRAM16_data, rd_data, ref_miss, timeout_err}, 64'd0);
    endtask

`ifdef DRAM_REFRESH_EN
    logic        r_rst;
    logic        r_req0_valid, r_req1_valid;
    logic [1:0]  r_req0_model, r_req1_model;
    logic [1:0]  r_req0_row, r_req1_row;
    logic [16:1] r_req0_data, r_req1_data;
    logic        r_req0_grant, r_req0_done, r_req0_err;
    logic        r_req1_grant, r_req1_done, r_req1_err;
    logic [16:1] r_rd_data;
    logic        r_IO_EN;
    logic [1:0]  r_IO_MODEL;
    logic [16:1] r_DRAM16_data;
    logic [1:0]  r_ROW_AD;
    logic        r_WT_DONE = 1'b0, r_RD_DONE = 1'b0;
    logic [16:1] r_RD_DATA = '0;
    logic        r_busy, r_ref_miss, r_timeout_err;
    int          r_wr_lat = 2;
    int          resp_cnt = 0;
    bit          resp_wr  = 1'b0;
    int          ref_cnt  = 0;

    dram_access_sched #(.ROW_W(2), .REF_PERIOD(16), .TIMEOUT(255)) dut_ref (
        .clk(clk), .rst(r_rst),
        .req0_valid(r_req0_valid), .req0_model(r_req0_model), .req0_row(r_req0_row), .req0_data(r_req0_data),
        .req0_grant(r_req0_grant), .req0_done(r_req0_done), .req0_err(r_req0_err),
        .req1_valid(r_req1_valid), .req1_model(r_req1_model), .req1_row(r_req1_row), .req1_data(r_req1_data),
        .req1_grant(r_req1_grant), .req1_done(r_req1_done), .req1_err(r_req1_err),
        .rd_data(r_rd_data), .IO_EN(r_IO_EN), .IO_MODEL(r_IO_MODEL), .DRAM16_data(r_DRAM16_data),
        .ROW_AD(r_ROW_AD), .WT_DONE(r_WT_DONE), .RD_DONE(r_RD_DONE), .RD_DATA(r_RD_DATA),
        .busy(r_busy), .ref_miss(r_ref_miss), .timeout_err(r_timeout_err)
    );

    // Sequencer model: done arrives 2 cycles after IO_EN (writes use r_wr_lat).
    always @(posedge clk) begin
        #1;
        r_WT_DONE = 1'b0;
        r_RD_DONE = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                if (resp_wr) r_WT_DONE = 1'b1;
                else begin
                    r_RD_DONE = 1'b1;
                    r_RD_DATA = 16'hBEEF;
                end
            end
        end
        if (r_IO_EN) begin
            resp_wr  = (r_IO_MODEL == 2'b01);
            resp_cnt = resp_wr ? r_wr_lat : 2;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!r_rst && r_IO_EN && r_IO_MODEL == 2'b11) begin
            check("ref_row", r_ROW_AD, ref_cnt % 4);
            check("ref_data_zero", r_DRAM16_data, 0);
            ref_cnt++;
        end
    end
`endif

    initial begin
        rst = 1'b1;
        {req0_valid, req1_valid, WT_DONE, RD_DONE} = '0;
        {req0_model, req1_model, req0_row, req1_row} = '0;
        {req0_data, req1_data, RD_DATA} = '0;
`ifdef DRAM_REFRESH_EN
        r_rst = 1'b1;
        {r_req0_valid, r_req1_valid, r_req0_model, r_req1_model, r_req0_row, r_req1_row} = '0;
        {r_req0_data, r_req1_data} = '0;
`endif
        repeat (3) tick();
        check_quiet("reset_state");
        rst = 1'b0;

        // Both requesters read together four times: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = i[0];
            tick();
            req0_valid = 1'b1; req0_model = 2'b10; req0_row = 4'(2 * i);
            req1_valid = 1'b1; req1_model = 2'b10; req1_row = 4'(2 * i + 1);
            #1;
            check("rr_grant0", req0_grant, !g);
            check("rr_grant1", req1_grant, g);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            check("rd_issue", {IO_EN, IO_MODEL, ROW_AD}, {1'b1, 2'b10, g ? 4'(2 * i + 1) : 4'(2 * i)});
            tick();
            if (i == 0) begin
                WT_DONE = 1'b1;
                tick();
                WT_DONE = 1'b0;
                #1;
                check("rd_ignores_wt", {busy, req0_done, req1_done}, 3'b100);
            end
            RD_DONE = 1'b1; RD_DATA = 16'h1234 + 16'(i);
            tick();
            RD_DONE = 1'b0; RD_DATA = '0;
            #1;
            check("rd_done", {req0_done, req1_done, req0_err, req1_err}, {!g, g, 2'b00});
            check("rd_data", rd_data, 16'h1234 + 16'(i));
        end

        // Single write: grant T, IO_EN T+1, WT_DONE during T+5, done T+6
        tick();
        req0_valid = 1'b1; req0_model = 2'b01; req0_row = 4'd3; req0_data = 16'hA5A5;
        #1;
        check("wr_grant", {req0_grant, req1_grant}, 2'b10);
        tick();
        req0_valid = 1'b0;
        #1;
        check("wr_issue", {IO_EN, IO_MODEL, ROW_AD, DRAM16_data}, {1'b1, 2'b01, 4'd3, 16'hA5A5});
        tick();
        #1;
        check("wr_hold", {IO_EN, IO_MODEL, ROW_AD, DRAM16_data, busy}, {1'b0, 2'b01, 4'd3, 16'hA5A5, 1'b1});
        tick();
        tick();
        RD_DONE = 1'b1;
        tick();
        RD_DONE = 1'b0; WT_DONE = 1'b1;
        #1;
        check("wr_ignores_rd", {busy, req0_done}, 2'b10);
        tick();
        WT_DONE = 1'b0;
        #1;
        check("wr_done", {req0_done, req0_err, req1_done}, 3'b100);
        check("wr_keeps_rd_data", rd_data, 16'h1237);
        tick();
        #1;
        check("wr_back_idle", {busy, IO_MODEL, ROW_AD, DRAM16_data}, 23'd0);

        // req1 write with no completion: abort after 8 WAIT cycles
        tick();
        req1_valid = 1'b1; req1_model = 2'b01; req1_row = 4'd9; req1_data = 16'h5A5A;
        #1;
        check("to_grant", req1_grant, 1'b1);
        tick();
        req1_valid = 1'b0;
        repeat (8) tick();
        #1;
        check("to_still_waiting", {busy, req1_done, timeout_err}, 3'b100);
        tick();
        #1;
        check("to_done", {req1_done, req1_err, timeout_err}, 3'b111);
        tick();
        #1;
        check("to_sticky", {busy, timeout_err}, 2'b01);

        // Illegal models: grant then immediate error done, no command strobe
        for (int n = 0; n < 2; n++) begin
            tick();
            if (n == 0) begin req0_valid = 1'b1; req0_model = 2'b00; req0_row = 4'd5; end
            else        begin req1_valid = 1'b1; req1_model = 2'b11; req1_row = 4'd6; end
            #1;
            check("ill_grant", {req0_grant, req1_grant}, n == 0 ? 2'b10 : 2'b01);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            check("ill_done", {req0_done, req0_err, req1_done, req1_err, IO_EN, IO_MODEL, ROW_AD},
                  n == 0 ? {4'b1100, 7'd0} : {4'b0011, 7'd0});
            tick();
            #1;
            check("ill_idle", {busy, IO_EN, req0_done, req1_done}, 4'd0);
        end

        // Reset in WAIT with a completion arriving at the same time
        tick();
        req1_valid = 1'b1; req1_model = 2'b10; req1_row = 4'd7;
        #1;
        check("rst_pre_grant", req1_grant, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        rst = 1'b1; RD_DONE = 1'b1; RD_DATA = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_quiet("rst_mid_wait");
        end
        rst = 1'b0; RD_DONE = 1'b0; RD_DATA = '0;
        tick();
        #1;
        check_quiet("rst_released");
        req0_valid = 1'b1; req0_model = 2'b01; req0_row = 4'd12; req0_data = 16'h0F0F;
        #1;
        check("post_rst_grant", req0_grant, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("post_rst_issue", {IO_EN, IO_MODEL, ROW_AD, DRAM16_data}, {1'b1, 2'b01, 4'd12, 16'h0F0F});
        tick();
        WT_DONE = 1'b1;
        tick();
        WT_DONE = 1'b0;
        #1;
        check("post_rst_done", {req0_done, req0_err}, 2'b10);

`ifdef DRAM_REFRESH_EN
        begin
            int k;
            repeat (2) tick();
            r_rst = 1'b0;
            repeat (16) tick();
            r_req1_valid = 1'b1; r_req1_model = 2'b10; r_req1_row = 2'd2;
            #1;
            check("ref_beats_req1", r_req1_grant, 1'b0);
            tick();
            check("ref_issue", {r_IO_EN, r_IO_MODEL, r_ROW_AD}, {1'b1, 2'b11, 2'd0});
            k = 0;
            while (!r_req1_grant && k < 20) begin tick(); k++; end
            check("ref_req1_granted", r_req1_grant, 1'b1);
            tick();
            r_req1_valid = 1'b0;
            k = 0;
            while (ref_cnt < 5 && k < 200) begin tick(); k++; end
            check("ref_count", ref_cnt >= 5, 1'b1);
            check("ref_no_miss", r_ref_miss, 1'b0);

            r_wr_lat = 40;
            r_req0_valid = 1'b1; r_req0_model = 2'b01; r_req0_row = 2'd1; r_req0_data = 16'h0001;
            #1;
            k = 0;
            while (!r_req0_grant && k < 40) begin tick(); k++; end
            check("stall_grant", r_req0_grant, 1'b1);
            tick();
            r_req0_valid = 1'b0;
            k = 0;
            while (!r_req0_done && k < 100) begin tick(); k++; end
            check("stall_done", {r_req0_done, r_req0_err}, 2'b10);
            check("stall_ref_miss", r_ref_miss, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
